dma_sample_writer: RTL and testbench
====================================

# dma_sample_writer

DMA-side writer for the data sample RAM. Accepts 16-bit samples from the serial receive path, buffers up to two of them, and writes them into a circular region of the sample RAM through the DMA port of the sample RAM mux (`d_addrs`/`d_datain`/`d_wr`). It writes only while the TDSP does not hold `t_grant`, and it raises a block interrupt to the TDSP after every `BLOCK_LEN` committed samples.

## Interface
- `BASE_ADDR`, 8'h00: first sample RAM address of the circular buffer.
- `BUF_LEN`, 64: number of slots in the buffer, 1..256; `BASE_ADDR + BUF_LEN - 1` is computed modulo 256.
- `BLOCK_LEN`, 8: committed samples per block interrupt, 1..255.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  one-cycle sample strobe from the receiver; there is no backpressure.
- `s_data`  in  16  sample value, qualified by `s_valid`.
- `t_grant`  in  1  TDSP bus grant; while it is 1 the mux ignores the DMA port.
- `d_req`  out  1  DMA request to the arbiter: 1 while the FIFO is non-empty.
- `d_addrs`  out  8  sample RAM address, registered.
- `d_datain`  out  16  sample RAM write data, registered.
- `d_wr`  out  1  sample RAM write strobe, registered.
- `blk_irq`  out  1  block-complete interrupt; level, sticky until acknowledged.
- `blk_ack`  in  1  clears `blk_irq`.
- `overrun`  out  1  sticky: a sample was dropped.
- `ovr_clr`  in  1  clears `overrun`.

## Operation
- Input FIFO holds 2 entries × 16 bits.
  - `s_valid` pushes `s_data` into the FIFO.
  - A push when the FIFO is full, with no pop in the same cycle, drops the new sample and sets `overrun`.
  - A push and a pop in the same cycle while full is accepted, and occupancy stays at 2.
- `offset` is an 8-bit register in 0..`BUF_LEN`-1. Write address = `BASE_ADDR + offset` modulo 256.
  - After `offset` = `BUF_LEN`-1 is committed, `offset` wraps to 0.
- FSM states:
  - IDLE: `d_wr`=0. If the FIFO is non-empty and `t_grant`=0: load `d_addrs`/`d_datain` from the current address and the FIFO head, and go to WRITE.
  - WRITE: `d_wr`=1.
    - If `t_grant`=0 this cycle, the write commits: pop the FIFO, advance `offset`, and increment the block count.
    - After a commit: if the FIFO still holds an entry, load the next address/data and stay in WRITE (back-to-back writes). Otherwise go to IDLE.
    - If `t_grant`=1 this cycle, the write does not commit: go to HOLD with address/data unchanged.
  - HOLD: `d_wr`=0, address/data held. When `t_grant`=0, go to WRITE and retry the same address/data.
- Block counter counts 0..`BLOCK_LEN`-1 on commits.
  - A commit at `BLOCK_LEN`-1 resets it to 0 and sets `blk_irq`.
  - `blk_ack` clears `blk_irq`. If `blk_ack` and a block completion occur in the same cycle, `blk_irq` stays 1.
- `ovr_clr` clears `overrun`. If `ovr_clr` and a drop occur in the same cycle, `overrun` stays 1.
- `d_req` = FIFO non-empty. It is derived from the registered occupancy only; there is no combinational path from any input.

## Timing
- Reset (asynchronous, active-low; mid-operation resets are allowed):
  - `d_wr`=0, `d_addrs`=`BASE_ADDR`, `d_datain`=0, `d_req`=0, `blk_irq`=0, `overrun`=0.
  - FIFO empty, `offset`=0, block count 0, FSM in IDLE.
  - A write that is in progress is abandoned and no retry follows.
- Latency when `t_grant`=0 and the FIFO and FSM are idle:
  - `s_valid` in cycle N → `d_req`=1 in N+1 → IDLE loads address/data in N+1 → `d_wr`=1 in N+2.
  - The write commits at the end of N+2. `d_req` falls in N+3 unless another sample is pending.
- Sustained throughput is 1 write per clock while `t_grant`=0 and the FIFO is non-empty.
- `d_addrs`/`d_datain` are stable for every cycle `d_wr`=1 and for the whole of HOLD.
- Each sample is committed exactly once, in arrival order.
- `blk_irq` rises in the cycle after the committing WRITE cycle.

## Test plan
- Single sample, `BASE_ADDR`=8'h40, `s_data`=16'hA5A5 at cycle N, `t_grant`=0 → exactly one `d_wr` pulse at N+2 with `d_addrs`=8'h40 and `d_datain`=16'hA5A5; the next sample goes to 8'h41.
- Wrap: `BUF_LEN`=4, 6 samples 1..6 spaced 3 cycles apart → addresses BASE+0,1,2,3,0,1 carrying data 1..6.
- Grant collision: `t_grant`=1 during the WRITE cycle of sample 16'h1234 at addr 8'h05 → `d_wr` drops and the FSM enters HOLD; `t_grant` falls 3 cycles later → `d_wr`=1 again with 8'h05/16'h1234. One commit total; the next address is 8'h06.
- Overrun: `t_grant`=1 held while 3 samples arrive → `overrun`=1 and `d_req`=1; on release, only samples 1 and 2 are written. `ovr_clr` → `overrun`=0.
- Block IRQ: `BLOCK_LEN`=4, 4 samples → `blk_irq`=1 one cycle after the 4th commit. `blk_ack` asserted in the same cycle as the 8th commit → `blk_irq` remains 1.
- Reset mid-HOLD with 2 samples queued → all outputs at reset values and the FIFO empty. The next sample is written to `BASE_ADDR` and there is no stale write.

Source files
------------

// File: rtl/dma_sample_writer.sv
// DMA-side writer for the sample RAM: buffers up to two received samples and
// writes them into a circular region while the TDSP does not hold the bus.
module dma_sample_writer #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned BUF_LEN   = 64,
  parameter int unsigned BLOCK_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  input  logic        t_grant,
  output logic        d_req,
  output logic [7:0]  d_addrs,
  output logic [15:0] d_datain,
  output logic        d_wr,
  output logic        blk_irq,
  input  logic        blk_ack,
  output logic        overrun,
  input  logic        ovr_clr
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [AW-1:0] LAST_OFF = AW'(BUF_LEN - 1);
  localparam logic [AW-1:0] LAST_BLK = AW'(BLOCK_LEN - 1);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [AW-1:0] offset_q, offset_d;
  logic [AW-1:0] blk_cnt_q, blk_cnt_d;
  logic [AW-1:0] d_addrs_q, d_addrs_d;
  logic [DW-1:0] d_datain_q, d_datain_d;
  logic          d_wr_q, d_wr_d;
  logic          d_req_q, d_req_d;
  logic          blk_irq_q, blk_irq_d;
  logic          overrun_q, overrun_d;

  logic          push, pop, drop, blk_done;
  logic [AW-1:0] offset_nxt;

  // FIFO bookkeeping, write FSM and sticky status flags
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    offset_d   = offset_q;
    blk_cnt_d  = blk_cnt_q;
    d_addrs_d  = d_addrs_q;
    d_datain_d = d_datain_q;
    blk_done   = 1'b0;

    pop        = (state_q == S_WRITE) && !t_grant;
    push       = s_valid && ((count_q != 2'd2) || pop);
    drop       = s_valid && (count_q == 2'd2) && !pop;
    offset_nxt = (offset_q == LAST_OFF) ? '0 : offset_q + AW'(1);

    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if ((count_q != 2'd0) && !t_grant) begin
          d_addrs_d  = BASE_ADDR + offset_q;
          d_datain_d = mem_q[rd_ptr_q];
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!t_grant) begin
          offset_d = offset_nxt;
          if (blk_cnt_q == LAST_BLK) begin
            blk_cnt_d = '0;
            blk_done  = 1'b1;
          end else begin
            blk_cnt_d = blk_cnt_q + AW'(1);
          end
          // Next head is the second stored entry, or the sample arriving now
          if (count_q == 2'd2) begin
            d_addrs_d  = BASE_ADDR + offset_nxt;
            d_datain_d = mem_q[~rd_ptr_q];
          end else if (push) begin
            d_addrs_d  = BASE_ADDR + offset_nxt;
            d_datain_d = s_data;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!t_grant) begin
          state_d = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    d_wr_d    = (state_d == S_WRITE);
    d_req_d   = (count_d != 2'd0);
    blk_irq_d = (blk_irq_q && !blk_ack) || blk_done;
    overrun_d = (overrun_q && !ovr_clr) || drop;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      offset_q   <= '0;
      blk_cnt_q  <= '0;
      d_addrs_q  <= BASE_ADDR;
      d_datain_q <= '0;
      d_wr_q     <= 1'b0;
      d_req_q    <= 1'b0;
      blk_irq_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      offset_q   <= offset_d;
      blk_cnt_q  <= blk_cnt_d;
      d_addrs_q  <= d_addrs_d;
      d_datain_q <= d_datain_d;
      d_wr_q     <= d_wr_d;
      d_req_q    <= d_req_d;
      blk_irq_q  <= blk_irq_d;
      overrun_q  <= overrun_d;
    end
  end

  assign d_req    = d_req_q;
  assign d_addrs  = d_addrs_q;
  assign d_datain = d_datain_q;
  assign d_wr     = d_wr_q;
  assign blk_irq  = blk_irq_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_dma_sample_writer.sv
// Directed bench for dma_sample_writer: latency, wrap, grant collision,
// overrun, block interrupt and mid-HOLD reset.
module tb_dma_sample_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        t_grant = 1'b0;
  logic        d_req;
  logic [7:0]  d_addrs;
  logic [15:0] d_datain;
  logic        d_wr;
  logic        blk_irq;
  logic        blk_ack = 1'b0;
  logic        overrun;
  logic        ovr_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  log_a [$];
  logic [15:0] log_d [$];
  int          wr_cycles = 0;

  dma_sample_writer #(.BASE_ADDR(8'h40), .BUF_LEN(4), .BLOCK_LEN(4)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .t_grant(t_grant), .d_req(d_req), .d_addrs(d_addrs), .d_datain(d_datain),
    .d_wr(d_wr), .blk_irq(blk_irq), .blk_ack(blk_ack), .overrun(overrun),
    .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  // Committed write = d_wr high in a cycle where the TDSP does not hold the bus
  always @(negedge clk) begin
    if (reset && d_wr) begin
      wr_cycles++;
      if (!t_grant) begin
        log_a.push_back(d_addrs);
        log_d.push_back(d_datain);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    s_valid = 1'b1;
    s_data  = v;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [7:0] a, input logic [15:0] d);
    logic [7:0]  ga;
    logic [15:0] gd;
    ga = (idx < log_a.size()) ? log_a[idx] : 8'hxx;
    gd = (idx < log_d.size()) ? log_d[idx] : 16'hxxxx;
    check({tag, "_addr"}, 32'(ga), 32'(a));
    check({tag, "_data"}, 32'(gd), 32'(d));
  endtask

  task automatic do_reset();
    s_valid = 1'b0; t_grant = 1'b0; blk_ack = 1'b0; ovr_clr = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_wr"},   32'(d_wr), 32'd0);
    check({tag, "_addr"}, 32'(d_addrs), 32'h40);
    check({tag, "_data"}, 32'(d_datain), 32'd0);
    check({tag, "_req"},  32'(d_req), 32'd0);
    check({tag, "_irq"},  32'(blk_irq), 32'd0);
    check({tag, "_ovr"},  32'(overrun), 32'd0);
  endtask

  initial begin
    int b, w;

    // Reset state and single-sample latency
    do_reset();
    chk_reset_vals("rst");
    b = log_a.size(); w = wr_cycles;
    send(16'hA5A5);
    @(negedge clk);
    check("lat_req_n1", 32'(d_req), 32'd1);
    check("lat_wr_n1",  32'(d_wr), 32'd0);
    tick();
    @(negedge clk);
    check("lat_wr_n2",   32'(d_wr), 32'd1);
    check("lat_addr_n2", 32'(d_addrs), 32'h40);
    check("lat_data_n2", 32'(d_datain), 32'hA5A5);
    tick();
    @(negedge clk);
    check("lat_wr_n3",  32'(d_wr), 32'd0);
    check("lat_req_n3", 32'(d_req), 32'd0);
    tick(); tick();
    check("single_pulses", 32'(wr_cycles - w), 32'd1);
    send(16'hB6B6);
    tick(); tick(); tick();
    check("single_cnt", 32'(log_a.size() - b), 32'd2);
    chk_wr("single0", b, 8'h40, 16'hA5A5);
    chk_wr("single1", b + 1, 8'h41, 16'hB6B6);

    // Circular wrap with a 4-slot buffer
    do_reset();
    b = log_a.size();
    for (int i = 1; i <= 6; i++) begin
      send(16'(i));
      tick(); tick();
    end
    tick();
    check("wrap_cnt", 32'(log_a.size() - b), 32'd6);
    chk_wr("wrap0", b,     8'h40, 16'd1);
    chk_wr("wrap1", b + 1, 8'h41, 16'd2);
    chk_wr("wrap2", b + 2, 8'h42, 16'd3);
    chk_wr("wrap3", b + 3, 8'h43, 16'd4);
    chk_wr("wrap4", b + 4, 8'h40, 16'd5);
    chk_wr("wrap5", b + 5, 8'h41, 16'd6);

    // Grant collision in the WRITE cycle, then retry after HOLD
    do_reset();
    b = log_a.size();
    send(16'h1111);
    tick(); tick(); tick();
    send(16'h1234);
    tick();
    t_grant = 1'b1;
    @(negedge clk);
    check("col_wr_first", 32'(d_wr), 32'd1);
    check("col_addr_first", 32'(d_addrs), 32'h41);
    tick();
    @(negedge clk);
    check("col_hold_wr", 32'(d_wr), 32'd0);
    check("col_hold_addr", 32'(d_addrs), 32'h41);
    check("col_hold_data", 32'(d_datain), 32'h1234);
    tick(); tick();
    t_grant = 1'b0;
    tick();
    @(negedge clk);
    check("col_retry_wr", 32'(d_wr), 32'd1);
    check("col_retry_addr", 32'(d_addrs), 32'h41);
    check("col_retry_data", 32'(d_datain), 32'h1234);
    tick(); tick();
    send(16'h5678);
    tick(); tick(); tick();
    check("col_cnt", 32'(log_a.size() - b), 32'd3);
    chk_wr("col0", b,     8'h40, 16'h1111);
    chk_wr("col1", b + 1, 8'h41, 16'h1234);
    chk_wr("col2", b + 2, 8'h42, 16'h5678);

    // Overrun while the TDSP holds the bus
    do_reset();
    b = log_a.size();
    t_grant = 1'b1;
    send(16'hAAA1);
    send(16'hAAA2);
    send(16'hAAA3);
    @(negedge clk);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_req", 32'(d_req), 32'd1);
    check("ovr_nowr", 32'(d_wr), 32'd0);
    tick();
    t_grant = 1'b0;
    repeat (5) tick();
    check("ovr_cnt", 32'(log_a.size() - b), 32'd2);
    chk_wr("ovr0", b,     8'h40, 16'hAAA1);
    chk_wr("ovr1", b + 1, 8'h41, 16'hAAA2);
    check("ovr_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);

    // Block interrupt timing and ack/completion collision
    do_reset();
    b = log_a.size();
    for (int i = 1; i <= 3; i++) begin
      send(16'(16'h0100 + i));
      tick(); tick();
    end
    send(16'h0104);
    @(negedge clk);
    check("irq_n1", 32'(blk_irq), 32'd0);
    tick();
    @(negedge clk);
    check("irq_n2_wr", 32'(d_wr), 32'd1);
    check("irq_n2", 32'(blk_irq), 32'd0);
    tick();
    @(negedge clk);
    check("irq_n3", 32'(blk_irq), 32'd1);
    tick();
    for (int i = 5; i <= 7; i++) begin
      send(16'(16'h0100 + i));
      tick(); tick();
    end
    check("irq_held", 32'(blk_irq), 32'd1);
    blk_ack = 1'b1;
    tick();
    blk_ack = 1'b0;
    check("irq_acked", 32'(blk_irq), 32'd0);
    send(16'h0108);
    tick();
    blk_ack = 1'b1;
    tick();
    blk_ack = 1'b0;
    check("irq_ack_collide", 32'(blk_irq), 32'd1);
    blk_ack = 1'b1;
    tick();
    blk_ack = 1'b0;
    check("irq_ack2", 32'(blk_irq), 32'd0);
    check("irq_cnt", 32'(log_a.size() - b), 32'd8);
    chk_wr("irq7", b + 7, 8'h43, 16'h0108);

    // Reset in HOLD with two samples queued
    do_reset();
    send(16'h0AAA);
    tick();
    t_grant = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h0BBB;
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    check("mid_hold_req", 32'(d_req), 32'd1);
    check("mid_hold_wr", 32'(d_wr), 32'd0);
    tick();
    #1;
    reset = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    t_grant = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    b = log_a.size(); w = wr_cycles;
    repeat (5) tick();
    check("mid_no_stale", 32'(wr_cycles - w), 32'd0);
    check("mid_req_empty", 32'(d_req), 32'd0);
    send(16'h7777);
    tick(); tick(); tick();
    check("mid_cnt", 32'(log_a.size() - b), 32'd1);
    chk_wr("mid0", b, 8'h40, 16'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
